lap_stopwatch: RTL and testbench
================================

LAP_STOPWATCH -- requirements
Module: lap_stopwatch

Interface
REQ-001 Parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 10, count-tick rate (one tick = one tenth-unit); CLK_HZ/TICK_HZ SHALL be an integer >= 2.
REQ-003 Parameter MAX_SEC, default 59, legal range 1..99, last seconds value before wrap.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 btn_ss  input  1  start/stop request, single-cycle synchronous pulse.
REQ-007 btn_lap  input  1  lap/clear request, single-cycle synchronous pulse.
REQ-008 left  output  7  seven-segment code of displayed seconds tens digit.
REQ-009 right  output  7  seven-segment code of displayed seconds ones digit.
REQ-010 side  output  10  one-hot of displayed tenths digit (bit n set for tenths = n).
REQ-011 state  output  2  FSM state: 00 IDLE, 01 RUN, 10 LAP, 11 STOP.
REQ-012 wrap  output  1  one-cycle pulse when seconds wrap MAX_SEC -> 0.

Function
REQ-013 Prescaler counts 0..DIV-1, DIV = CLK_HZ/TICK_HZ; tick asserted for one cycle when prescaler = DIV-1 and counting enabled; prescaler then returns to 0.
REQ-014 Counting enabled in RUN and LAP only; prescaler, tenths and seconds hold in STOP; all three are 0 in IDLE.
REQ-015 On tick: tenths increments 0..9; at 9 it returns to 0 and seconds increments; seconds at MAX_SEC with tenths 9 returns to 0 and wrap pulses in the following cycle.
REQ-016 FSM transitions (btn_ss has priority when both pulse in one cycle): IDLE+btn_ss -> RUN; RUN+btn_ss -> STOP; RUN+btn_lap -> LAP; LAP+btn_lap -> RUN; LAP+btn_ss -> STOP; STOP+btn_ss -> RUN (resume from held count); STOP+btn_lap -> IDLE (count cleared); all other inputs leave the state unchanged.
REQ-017 btn_lap in IDLE and btn_ss/btn_lap together in IDLE: only btn_ss acts (-> RUN).
REQ-018 Display registers (disp_tenths, disp_sec) load the live count every cycle in IDLE, RUN and STOP, and are frozen in LAP; outputs therefore lag the live count by one cycle.
REQ-019 On LAP -> RUN or LAP -> STOP the display resumes loading the live count on the next cycle; counting is never interrupted by LAP entry or exit.
REQ-020 left = segment code of disp_sec/10, right = segment code of disp_sec%10, side = 10'b1 << disp_tenths; outputs are combinational from display registers.
REQ-021 Segment code, bit order gfedcba, active-high: 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F (hex); codes 10-15 never occur.
REQ-022 Seconds width SHALL be 7 bits; tenths 4 bits; prescaler width ceil(log2(DIV)).
REQ-023 A tick coinciding with RUN -> STOP (btn_ss) SHALL still be counted; a tick cannot coincide with STOP -> RUN since the prescaler restarts from its held value.

Reset
REQ-024 reset low immediately forces state=IDLE, prescaler=0, tenths=0, seconds=0, display registers=0, wrap=0, independent of clk.
REQ-025 Reset outputs: left=3F, right=3F, side=10'b0000000001, state=00, wrap=0.
REQ-026 Reset asserted mid-RUN or mid-LAP discards the count; release leaves block in IDLE with no pending button effect.

Verification (CLK_HZ=100, TICK_HZ=10, DIV=10, MAX_SEC=59 unless stated)
REQ-027 Reset pulse then idle 50 cycles -> state=00, left=right=3F, side=001 (hex), no wrap.
REQ-028 btn_ss, run 10 ticks (100 cycles) -> disp seconds 1, tenths 0: right=06, left=3F, side=001, state=01.
REQ-029 Run 2.3 s, btn_lap, run 30 more ticks -> outputs frozen at 02.3 (right=5B, side=008); btn_lap -> next cycle shows 05.3 (right=6D), state=01.
REQ-030 Run 4.0 s, btn_ss, wait 200 cycles -> display holds 04.0, state=11; btn_ss, 10 ticks -> 05.0; btn_ss then btn_lap -> state=00, display 00.0.
REQ-031 MAX_SEC=3: run 4.0 s -> display 00.0 after wrap, wrap high exactly one cycle; btn_ss and btn_lap same cycle in RUN -> state=11.
REQ-032 Assert reset for 1 cycle mid-LAP at 07.5 -> asynchronous return to 00.0, state=00; subsequent btn_ss restarts from 00.0.

Source files
------------

// File: rtl/lap_stopwatch.sv
// Lap stopwatch: tenths/seconds counter with run/lap/stop control and 7-segment display.
`timescale 1ns/1ps
module lap_stopwatch #(
    parameter int unsigned CLK_HZ  = 50000000,
    parameter int unsigned TICK_HZ = 10,
    parameter int unsigned MAX_SEC = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_ss,
    input  logic       btn_lap,
    output logic [6:0] left,
    output logic [6:0] right,
    output logic [9:0] side,
    output logic [1:0] state,
    output logic       wrap
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SW  = 7;
    localparam int unsigned TW  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        LAP  = 2'b10,
        STOP = 2'b11
    } state_t;

    state_t        state_q;
    logic [PW-1:0] presc;
    logic [TW-1:0] tenths;
    logic [SW-1:0] sec;
    logic [TW-1:0] disp_tenths;
    logic [SW-1:0] disp_sec;
    logic          counting;
    logic          tick;
    logic          clear;

    // Segment code, gfedcba, active-high.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Control FSM; start/stop wins over lap when both pulse together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: if (btn_ss) state_q <= RUN;
                RUN: begin
                    if (btn_ss)       state_q <= STOP;
                    else if (btn_lap) state_q <= LAP;
                end
                LAP: begin
                    if (btn_ss)       state_q <= STOP;
                    else if (btn_lap) state_q <= RUN;
                end
                STOP: begin
                    if (btn_ss)       state_q <= RUN;
                    else if (btn_lap) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Count enable, tick strobe, and clear (IDLE, or STOP leaving to IDLE).
    always_comb begin
        counting = (state_q == RUN) || (state_q == LAP);
        tick     = counting && (presc == PW'(DIV - 1));
        clear    = (state_q == IDLE) || ((state_q == STOP) && btn_lap && !btn_ss);
    end

    // Prescaler, tenths and seconds counters plus registered wrap pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc  <= '0;
            tenths <= '0;
            sec    <= '0;
            wrap   <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (clear) begin
                presc  <= '0;
                tenths <= '0;
                sec    <= '0;
            end else if (counting) begin
                if (tick) begin
                    presc <= '0;
                    if (tenths == TW'(9)) begin
                        tenths <= '0;
                        if (sec == SW'(MAX_SEC)) begin
                            sec  <= '0;
                            wrap <= 1'b1;
                        end else begin
                            sec <= sec + SW'(1);
                        end
                    end else begin
                        tenths <= tenths + TW'(1);
                    end
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

    // Display registers track the live count except while a lap is frozen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disp_tenths <= '0;
            disp_sec    <= '0;
        end else if (state_q != LAP) begin
            disp_tenths <= tenths;
            disp_sec    <= sec;
        end
    end

    // Output decode straight from the display registers.
    always_comb begin
        left  = seg7(4'(disp_sec / SW'(10)));
        right = seg7(4'(disp_sec % SW'(10)));
        side  = 10'(1) << disp_tenths;
        state = state_q;
    end

endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench for lap_stopwatch: two instances (MAX_SEC 59 and 3) against a cycle-count model.
`timescale 1ns/1ps
module tb_lap_stopwatch;

    localparam int CLK_HZ  = 100;
    localparam int TICK_HZ = 10;
    localparam int DIV     = CLK_HZ / TICK_HZ;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_ss = 1'b0;
    logic       btn_lap = 1'b0;
    logic [6:0] left0, right0, left1, right1;
    logic [9:0] side0, side1;
    logic [1:0] state0, state1;
    logic       wrap0, wrap1;

    int ntests = 0;
    int nfail  = 0;

    logic [6:0] seg [10];
    int maxs [2];
    int ms;
    int rc [2];
    int dsp [2];
    bit wexp [2];

    always #5 clk = ~clk;

    lap_stopwatch #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .MAX_SEC(59)) dut0 (
        .clk(clk), .reset(reset), .btn_ss(btn_ss), .btn_lap(btn_lap),
        .left(left0), .right(right0), .side(side0), .state(state0), .wrap(wrap0)
    );

    lap_stopwatch #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .MAX_SEC(3)) dut1 (
        .clk(clk), .reset(reset), .btn_ss(btn_ss), .btn_lap(btn_lap),
        .left(left1), .right(right1), .side(side1), .state(state1), .wrap(wrap1)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int period(input int i);
        return 10 * (maxs[i] + 1);
    endfunction

    task automatic model_reset();
        ms = 0;
        for (int i = 0; i < 2; i++) begin
            rc[i] = 0; dsp[i] = 0; wexp[i] = 1'b0;
        end
    endtask

    // Model: elapsed counting cycles -> tenths; display samples the count unless in LAP.
    task automatic model_edge(input bit ss, input bit lap);
        int ns;
        ns = ms;
        for (int i = 0; i < 2; i++) begin
            if (ms != 2) dsp[i] = (rc[i] / DIV) % period(i);
            wexp[i] = 1'b0;
            if (ms == 1 || ms == 2) begin
                rc[i]++;
                if (rc[i] % (DIV * period(i)) == 0) wexp[i] = 1'b1;
            end
        end
        case (ms)
            0: if (ss) ns = 1;
            1: if (ss) ns = 3; else if (lap) ns = 2;
            2: if (ss) ns = 3; else if (lap) ns = 1;
            3: if (ss) ns = 1; else if (lap) ns = 0;
            default: ns = 0;
        endcase
        if (ns == 0) begin
            rc[0] = 0; rc[1] = 0;
        end
        ms = ns;
    endtask

    task automatic check_model(input string tag);
        int s, t;
        logic [9:0] sx;
        chk({tag, ".state0"}, 16'(state0), 16'(ms));
        chk({tag, ".state1"}, 16'(state1), 16'(ms));
        s = dsp[0] / 10; t = dsp[0] % 10; sx = 10'd1 << t;
        chk({tag, ".left0"},  16'(left0),  16'(seg[s / 10]));
        chk({tag, ".right0"}, 16'(right0), 16'(seg[s % 10]));
        chk({tag, ".side0"},  16'(side0),  16'(sx));
        chk({tag, ".wrap0"},  16'(wrap0),  16'(wexp[0]));
        s = dsp[1] / 10; t = dsp[1] % 10; sx = 10'd1 << t;
        chk({tag, ".left1"},  16'(left1),  16'(seg[s / 10]));
        chk({tag, ".right1"}, 16'(right1), 16'(seg[s % 10]));
        chk({tag, ".side1"},  16'(side1),  16'(sx));
        chk({tag, ".wrap1"},  16'(wrap1),  16'(wexp[1]));
    endtask

    task automatic step(input bit ss, input bit lap, input string tag);
        btn_ss  = ss;
        btn_lap = lap;
        @(posedge clk);
        model_edge(ss, lap);
        #1;
        btn_ss  = 1'b0;
        btn_lap = 1'b0;
        check_model(tag);
    endtask

    task automatic chk_disp0(input string tag, input logic [6:0] l, input logic [6:0] r,
                             input logic [9:0] sd, input logic [1:0] st);
        chk({tag, ".left"},  16'(left0),  16'(l));
        chk({tag, ".right"}, 16'(right0), 16'(r));
        chk({tag, ".side"},  16'(side0),  16'(sd));
        chk({tag, ".state"}, 16'(state0), 16'(st));
    endtask

    initial begin
        int wc;
        seg = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        maxs[0] = 59;
        maxs[1] = 3;
        model_reset();

        // Asynchronous reset before any clock edge.
        #2 reset = 1'b0;
        #1;
        chk_disp0("rst_async", 7'h3F, 7'h3F, 10'h001, 2'b00);
        chk("rst_async.wrap", 16'(wrap0), 16'(0));
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;

        // Idle 50 cycles.
        repeat (50) step(1'b0, 1'b0, "idle");
        chk_disp0("idle50", 7'h3F, 7'h3F, 10'h001, 2'b00);
        chk("idle50.wrap", 16'(wrap0), 16'(0));

        // Start and run ten ticks (plus the one-cycle display lag).
        step(1'b1, 1'b0, "start");
        repeat (101) step(1'b0, 1'b0, "run1s");
        chk_disp0("run1s", 7'h3F, 7'h06, 10'h001, 2'b01);

        // Lap at 2.3 s, keep counting, then release.
        repeat (130) step(1'b0, 1'b0, "run23");
        step(1'b0, 1'b1, "lap_in");
        repeat (300) step(1'b0, 1'b0, "lapheld");
        chk_disp0("lap_frozen", 7'h3F, 7'h5B, 10'h008, 2'b10);
        step(1'b0, 1'b1, "lap_out");
        step(1'b0, 1'b0, "lap_out1");
        chk_disp0("lap_resume", 7'h3F, 7'h6D, 10'h008, 2'b01);

        // Stop, clear, then run 4.0 s and stop/resume.
        step(1'b1, 1'b0, "stop_a");
        step(1'b0, 1'b1, "clear_a");
        chk("clear_a.state", 16'(state0), 16'(0));
        step(1'b1, 1'b0, "start_b");
        repeat (401) step(1'b0, 1'b0, "run4s");
        step(1'b1, 1'b0, "stop_b");
        repeat (200) step(1'b0, 1'b0, "stopheld");
        chk_disp0("stop_hold", 7'h3F, 7'h66, 10'h001, 2'b11);
        step(1'b1, 1'b0, "resume");
        repeat (100) step(1'b0, 1'b0, "run5s");
        chk_disp0("resume5s", 7'h3F, 7'h6D, 10'h001, 2'b01);
        step(1'b1, 1'b0, "stop_c");
        step(1'b0, 1'b1, "clear_c");
        step(1'b0, 1'b0, "idle_c");
        chk_disp0("cleared", 7'h3F, 7'h3F, 10'h001, 2'b00);

        // Wrap of the MAX_SEC=3 instance after 4.0 s, then simultaneous buttons.
        step(1'b1, 1'b0, "start_w");
        wc = 0;
        for (int k = 0; k < 401; k++) begin
            step(1'b0, 1'b0, "run_w");
            if (wrap1) wc++;
        end
        chk("wrap1.count", 16'(wc), 16'(1));
        chk("wrap1.left",  16'(left1),  16'(7'h3F));
        chk("wrap1.right", 16'(right1), 16'(7'h3F));
        chk("wrap1.side",  16'(side1),  16'(10'h001));
        step(1'b1, 1'b1, "both");
        chk("both.state", 16'(state1), 16'(2'b11));

        // Lap at 7.5 s, then a one-cycle asynchronous reset.
        step(1'b0, 1'b1, "clear_d");
        step(1'b1, 1'b0, "start_d");
        repeat (751) step(1'b0, 1'b0, "run75");
        step(1'b0, 1'b1, "lap75");
        repeat (5) step(1'b0, 1'b0, "lap75h");
        chk_disp0("lap75", 7'h3F, 7'h07, 10'h020, 2'b10);
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk_disp0("rst_mid", 7'h3F, 7'h3F, 10'h001, 2'b00);
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (3) step(1'b0, 1'b0, "post_rst");
        step(1'b1, 1'b0, "restart");
        repeat (25) step(1'b0, 1'b0, "rerun");
        chk_disp0("rerun", 7'h3F, 7'h3F, 10'h004, 2'b01);

        // Long run across the 59.9 -> 00.0 wrap.
        wc = 0;
        for (int k = 0; k < 6000; k++) begin
            step(1'b0, 1'b0, "long");
            if (wrap0) wc++;
        end
        chk("wrap0.count", 16'(wc), 16'(1));

        // Random button traffic.
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 29) == 0), ($urandom_range(0, 19) == 0), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
